pmem_burst_adapter: RTL



---
 rtl/pmem_burst_adapter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pmem_burst_adapter.sv
// Cache-line to narrow-burst adapter: latches one 256-bit line request and moves
// it as ascending BEAT_WIDTH beats, returning a one-cycle pmem_resp at the end.
module pmem_burst_adapter #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_address,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [BEAT_WIDTH-1:0] mem_rdata
);

  // state    | meaning
  // ST_IDLE  | waiting for a line request; read wins if both are raised
  // ST_READ  | collecting read beats from the memory side
  // ST_WRITE | presenting write beats from the latched line
  // ST_DONE  | one-cycle pmem_resp, then back to idle

  localparam int BEATS     = LINE_WIDTH / BEAT_WIDTH;
  localparam int BEAT_BITS = $clog2(BEATS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BEAT_BITS-1:0]  beat_q;
  logic                  last_beat;
  logic                  accept;
  logic                  beat_done;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [LINE_WIDTH-1:0] rbuf_q;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic [LINE_WIDTH-1:0] rline_d;
  logic [BEAT_WIDTH-1:0] wdata_sel;

  assign last_beat = (beat_q == BEAT_BITS'(BEATS - 1));
  assign accept    = (state_q == ST_IDLE) && (pmem_read || pmem_write);
  assign beat_done = ((state_q == ST_READ) || (state_q == ST_WRITE)) && mem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pmem_read) begin
          state_d = ST_READ;
        end else if (pmem_write) begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        if (mem_resp && last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (mem_resp && last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat mux for the outgoing write slice and merge of the incoming read slice.
  always_comb begin
    wdata_sel = '0;
    rline_d   = rbuf_q;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_q == BEAT_BITS'(i)) begin
        wdata_sel                           = wline_q[i*BEAT_WIDTH +: BEAT_WIDTH];
        rline_d[i*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= pmem_address & ~32'h0000_001f;
        beat_q <= '0;
        if (!pmem_read) begin
          wline_q <= pmem_wdata;
        end
      end
      if (beat_done) begin
        beat_q <= last_beat ? '0 : beat_q + BEAT_BITS'(1);
        if (state_q == ST_READ) begin
          rbuf_q <= rline_d;
          // Visible read data only changes once the whole line has arrived.
          if (last_beat) begin
            rdata_q <= rline_d;
          end
        end
      end
    end
  end

  assign pmem_resp   = (state_q == ST_DONE);
  assign pmem_rdata  = rdata_q;
  assign mem_read    = (state_q == ST_READ);
  assign mem_write   = (state_q == ST_WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = (state_q == ST_WRITE) ? wdata_sel : '0;

endmodule
